// File: rtl/karatsuba32_seq_ctrl.sv
// Sequential 32x32 Karatsuba controller driving one shared 18-bit multiplier.
// Optional build macro KSEQ_Z1_CLAMP_EN clamps a negative middle term to zero.
module karatsuba32_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] p,
  output logic [17:0] mul_x,
  output logic [17:0] mul_y,
  input  logic [35:0] mul_p,
  output logic        busy,
  output logic        z1_clamped
);

  typedef enum logic [2:0] {IDLE, MZ0, MZ2, MZ1, COMB, DONE} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        a_reg, b_reg;
  logic [35:0]        z0_reg, z2_reg, s_reg;
  logic [63:0]        p_reg;
  logic               out_valid_reg;
  logic [17:0]        mul_x_reg, mul_y_reg;
  logic [16:0]        sum_a, sum_b;
  logic signed [37:0] m_raw, m_used;
  logic [63:0]        p_calc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = MZ0;
      MZ0:     state_next = MZ2;
      MZ2:     state_next = MZ1;
      MZ1:     state_next = COMB;
      COMB:    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state_reg == IDLE);
    busy     = (state_reg != IDLE);
  end

  assign sum_a = {1'b0, a_reg[31:16]} + {1'b0, a_reg[15:0]};
  assign sum_b = {1'b0, b_reg[31:16]} + {1'b0, b_reg[15:0]};

  // Middle term goes negative only if the multiplier is approximate.
  assign m_raw = $signed({2'b00, s_reg}) - $signed({2'b00, z2_reg}) - $signed({2'b00, z0_reg});

`ifdef KSEQ_Z1_CLAMP_EN
  logic z1_clamped_reg;
  logic clamp_hit;
  assign clamp_hit  = m_raw[37];
  assign m_used     = clamp_hit ? '0 : m_raw;
  assign z1_clamped = z1_clamped_reg;

  always_ff @(posedge clk) begin
    if (rst)                    z1_clamped_reg <= 1'b0;
    else if (state_reg == COMB) z1_clamped_reg <= clamp_hit;
  end
`else
  assign m_used     = m_raw;
  assign z1_clamped = 1'b0;
`endif

  assign p_calc = {z2_reg[31:0], 32'b0} + ({{26{m_used[37]}}, m_used} << 16) + {28'b0, z0_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      z0_reg        <= '0;
      z2_reg        <= '0;
      s_reg         <= '0;
      p_reg         <= '0;
      out_valid_reg <= 1'b0;
      mul_x_reg     <= '0;
      mul_y_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          a_reg     <= a;
          b_reg     <= b;
          mul_x_reg <= {2'b00, a[15:0]};
          mul_y_reg <= {2'b00, b[15:0]};
        end
        MZ0: begin
          z0_reg    <= mul_p;
          mul_x_reg <= {2'b00, a_reg[31:16]};
          mul_y_reg <= {2'b00, b_reg[31:16]};
        end
        MZ2: begin
          z2_reg    <= mul_p;
          mul_x_reg <= {1'b0, sum_a};
          mul_y_reg <= {1'b0, sum_b};
        end
        MZ1: begin
          s_reg     <= mul_p;
          mul_x_reg <= '0;
          mul_y_reg <= '0;
        end
        COMB: begin
          p_reg         <= p_calc;
          out_valid_reg <= 1'b1;
        end
        DONE: if (out_ready) out_valid_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign p         = p_reg;
  assign out_valid = out_valid_reg;
  assign mul_x     = mul_x_reg;
  assign mul_y     = mul_y_reg;

endmodule
